// File: rtl/spiram_ctrl_if.sv
// CPU memory bus plus SPI pins of the serial SRAM bridge, bundled as one port.
// The slave modport is the controller; the master modport is the CPU/SRAM side.
interface spiram_ctrl_if #(
   parameter int ADDR_W = 15
);
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [3:0]        mem_wmask;
   logic              mem_rstrb;
   logic [31:0]       mem_rdata;
   logic              mem_rbusy;
   logic              mem_wbusy;
   logic              spi_cs_n;
   logic              spi_sck;
   logic              spi_mosi;
   logic              spi_miso;

   modport slave (
      input  mem_addr, mem_wdata, mem_wmask, mem_rstrb, spi_miso,
      output mem_rdata, mem_rbusy, mem_wbusy, spi_cs_n, spi_sck, spi_mosi
   );

   modport master (
      output mem_addr, mem_wdata, mem_wmask, mem_rstrb, spi_miso,
      input  mem_rdata, mem_rbusy, mem_wbusy, spi_cs_n, spi_sck, spi_mosi
   );
endinterface

// File: rtl/spiram_ctrl.sv
// SPI mode-0 master that turns each femtoRV word read or masked write into one
// CS-framed 23K256 transaction (cmd, 16-bit address, data bytes, MSB first).
// Handshake: a request is a cycle with mem_rstrb=1 or mem_wmask!=0 while the
// controller is idle; it is taken on that edge, the matching busy flag is high
// from the accept edge until the edge that returns to idle, and requests seen
// while busy are dropped. A write beats a read on the same edge.
module spiram_ctrl #(
   parameter int CLK_DIV = 2,
   parameter int ADDR_W  = 15
) (
   input  logic         clk,
   input  logic         reset,
   spiram_ctrl_if.slave bus,
   output logic [2:0]   state_dbg
);
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      CS_SETUP = 3'd1,
      SHIFT    = 3'd2,
      CS_HOLD  = 3'd3,
      CS_GAP   = 3'd4
   } state_t;

   state_t           state, state_next;
   logic [DIV_W-1:0] div_cnt;
   logic             phase;        // sck level inside SHIFT
   logic [5:0]       bit_cnt;
   logic [5:0]       last_bit;
   logic [55:0]      tx_sreg;
   logic [31:0]      rx_sreg;
   logic [31:0]      rdata;
   logic             mosi;
   logic             op_write;

   logic             accept_w, accept_r;
   logic             seg_end, rise_edge, fall_edge, frame_end;
   logic [1:0]       lo_idx, hi_idx, addr_lo;
   logic [2:0]       n_bytes;
   logic [5:0]       frame_last;
   logic [15:0]      frame_addr;
   logic [31:0]      data_al;
   logic [55:0]      frame_load;
   logic             unused_bits;

   assign accept_w  = (state == IDLE) && (bus.mem_wmask != 4'b0000);
   assign accept_r  = (state == IDLE) && bus.mem_rstrb && (bus.mem_wmask == 4'b0000);
   assign seg_end   = (div_cnt == DIV_W'(CLK_DIV - 1));
   assign rise_edge = (state == SHIFT) && seg_end && !phase;
   assign fall_edge = (state == SHIFT) && seg_end && phase;
   assign frame_end = fall_edge && (bit_cnt == last_bit);

   // Lowest/highest enabled byte lane; holes inside the span are still sent.
   always_comb begin
      lo_idx = 2'd0;
      hi_idx = 2'd0;
      for (int i = 3; i >= 0; i--)
         if (bus.mem_wmask[i]) lo_idx = 2'(i);
      for (int i = 0; i < 4; i++)
         if (bus.mem_wmask[i]) hi_idx = 2'(i);
   end

   // Build the full outgoing frame from the request as it stands on the accept edge.
   always_comb begin
      addr_lo    = accept_w ? lo_idx : 2'b00;
      n_bytes    = accept_w ? (3'(hi_idx) - 3'(lo_idx) + 3'd1) : 3'd4;
      frame_last = 6'd23 + {n_bytes, 3'b000};
      frame_addr = 16'({bus.mem_addr[ADDR_W-1:2], addr_lo});
      data_al    = accept_w ? (bus.mem_wdata >> {lo_idx, 3'b000}) : 32'h0;
      frame_load = {(accept_w ? 8'h02 : 8'h03), frame_addr,
                    data_al[7:0], data_al[15:8], data_al[23:16], data_al[31:24]};
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state and pin decode.
   always_comb begin
      state_next    = state;
      bus.spi_cs_n  = 1'b1;
      bus.spi_sck   = 1'b0;
      bus.mem_rbusy = 1'b0;
      bus.mem_wbusy = 1'b0;
      unique case (state)
         IDLE:     if (accept_w || accept_r) state_next = CS_SETUP;
         CS_SETUP: if (seg_end)   state_next = SHIFT;
         SHIFT:    if (frame_end) state_next = CS_HOLD;
         CS_HOLD:  if (seg_end)   state_next = CS_GAP;
         CS_GAP:   if (seg_end)   state_next = IDLE;
         default:                 state_next = IDLE;
      endcase
      if (state == CS_SETUP || state == SHIFT || state == CS_HOLD) bus.spi_cs_n = 1'b0;
      if (state == SHIFT && phase) bus.spi_sck = 1'b1;
      if (state != IDLE) begin
         bus.mem_rbusy = !op_write;
         bus.mem_wbusy = op_write;
      end
   end

   // Timing counters, shift registers and the read-data latch.
   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt  <= '0;
         phase    <= 1'b0;
         bit_cnt  <= 6'd0;
         last_bit <= 6'd0;
         tx_sreg  <= 56'h0;
         rx_sreg  <= 32'h0;
         rdata    <= 32'h0;
         mosi     <= 1'b0;
         op_write <= 1'b0;
      end else if (state == IDLE) begin
         div_cnt <= '0;
         phase   <= 1'b0;
         bit_cnt <= 6'd0;
         if (accept_w || accept_r) begin
            op_write <= accept_w;
            tx_sreg  <= frame_load;
            mosi     <= frame_load[55];
            last_bit <= frame_last;
         end
      end else begin
         div_cnt <= seg_end ? '0 : div_cnt + 1'b1;
         if (state == SHIFT && seg_end) phase <= ~phase;
         // Every bit is shifted in; only the last 32 (the data bytes) survive.
         if (rise_edge) rx_sreg <= {rx_sreg[30:0], bus.spi_miso};
         if (fall_edge) begin
            if (frame_end) begin
               mosi <= 1'b0;
            end else begin
               bit_cnt <= bit_cnt + 6'd1;
               tx_sreg <= {tx_sreg[54:0], 1'b0};
               mosi    <= tx_sreg[54];
            end
         end
         // First received byte lands in the low lane.
         if (state == CS_HOLD && seg_end && !op_write)
            rdata <= {rx_sreg[7:0], rx_sreg[15:8], rx_sreg[23:16], rx_sreg[31:24]};
      end
   end

   assign bus.spi_mosi  = mosi;
   assign bus.mem_rdata = rdata;
   assign state_dbg     = state;
   assign unused_bits   = ^{bus.mem_addr[1:0], tx_sreg[55]};
endmodule

// File: tb/tb_spiram_ctrl.sv
// Bench for spiram_ctrl: behavioural 23K256 on the SPI pins, table of directed
// transactions, hand sequences for ignored requests and mid-frame reset, then
// random reads/writes against a byte-array reference model.
module tb_spiram_ctrl;
   localparam int CLK_DIV = 2;
   localparam int ADDR_W  = 15;
   localparam int MAX_CYC = 5000;

   logic       clk;
   logic       reset;
   logic [2:0] state_dbg;

   spiram_ctrl_if #(.ADDR_W(ADDR_W)) bif ();

   spiram_ctrl #(.CLK_DIV(CLK_DIV), .ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bif.slave),
      .state_dbg (state_dbg)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // ---------------- SRAM device model ----------------
   logic [7:0]  sram [0:32767];
   logic [7:0]  rx_bytes [$];
   int          rise_cnt;
   int          frame_cnt;
   int          total_rises;
   logic [15:0] sl_addr;

   always @(posedge bif.spi_sck) total_rises++;

   initial begin : sram_model
      logic [7:0]  cur;
      logic [7:0]  rb;
      logic [14:0] wa;
      int          nbit;
      int          k;
      for (int i = 0; i < 32768; i++) sram[i] = 8'h00;
      bif.spi_miso = 1'b0;
      rise_cnt = 0;
      frame_cnt = 0;
      total_rises = 0;
      sl_addr = 16'h0;
      forever begin
         @(negedge bif.spi_cs_n);
         rx_bytes.delete();
         rise_cnt = 0;
         cur = 8'h00;
         nbit = 0;
         while (bif.spi_cs_n == 1'b0) begin
            @(bif.spi_sck or bif.spi_cs_n);
            if (bif.spi_cs_n) break;
            if (bif.spi_sck) begin
               cur = {cur[6:0], bif.spi_mosi};
               nbit++;
               rise_cnt++;
               if (nbit == 8) begin
                  rx_bytes.push_back(cur);
                  nbit = 0;
                  if (rx_bytes.size() == 3) sl_addr = {rx_bytes[1], rx_bytes[2]};
               end
            end else begin
               k = rise_cnt;
               if (k >= 24 && k < 56 && rx_bytes[0] == 8'h03) begin
                  wa = sl_addr[14:0] + 15'((k - 24) / 8);
                  rb = sram[wa];
                  bif.spi_miso = rb[7 - (k % 8)];
               end else begin
                  bif.spi_miso = 1'b0;
               end
            end
         end
         bif.spi_miso = 1'b0;
         if (rx_bytes.size() > 3 && rx_bytes[0] == 8'h02) begin
            for (int i = 3; i < rx_bytes.size(); i++) begin
               wa = sl_addr[14:0] + 15'(i - 3);
               sram[wa] = rx_bytes[i];
            end
         end
         frame_cnt++;
      end
   end

   // ---------------- reference model and scoreboard ----------------
   logic [7:0]  ref_mem [0:32767];
   logic [7:0]  exp_q [$];
   int          exp_total;
   int          exp_lat;
   logic        exp_write;
   logic [31:0] exp_rdata;
   int          checks;
   int          errors;
   int          lat;
   int          cs_low;
   logic        saw_rb;
   logic        saw_wb;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // A write stores every byte from the lowest to the highest enabled lane.
   task automatic ref_write(input logic [3:0] m, input logic [14:0] a, input logic [31:0] d);
      int lo, hi;
      lo = 0;
      while (m[lo] == 1'b0) lo++;
      hi = 3;
      while (m[hi] == 1'b0) hi--;
      for (int k = lo; k <= hi; k++) ref_mem[{a[14:2], 2'(k)}] = d[8*k +: 8];
   endtask

   // Expected frame, latency and read data for one request, from the byte-level rules.
   task automatic model_expect(input logic [3:0] m, input logic [14:0] addr, input logic [31:0] d);
      int          lo, hi;
      logic [14:0] a;
      exp_q.delete();
      if (m != 4'b0000) begin
         lo = 0;
         while (m[lo] == 1'b0) lo++;
         hi = 3;
         while (m[hi] == 1'b0) hi--;
         a = {addr[14:2], 2'(lo)};
         exp_q.push_back(8'h02);
         exp_q.push_back({1'b0, a[14:8]});
         exp_q.push_back(a[7:0]);
         for (int k = lo; k <= hi; k++) exp_q.push_back(d[8*k +: 8]);
         exp_total = 3 + (hi - lo + 1);
         exp_write = 1'b1;
         ref_write(m, addr, d);
      end else begin
         a = {addr[14:2], 2'b00};
         exp_q.push_back(8'h03);
         exp_q.push_back({1'b0, a[14:8]});
         exp_q.push_back(a[7:0]);
         exp_total = 7;
         exp_write = 1'b0;
         exp_rdata = {ref_mem[a + 15'd3], ref_mem[a + 15'd2], ref_mem[a + 15'd1], ref_mem[a]};
      end
      exp_lat = CLK_DIV * (3 + 16 * exp_total);
   endtask

   // ---------------- driver tasks ----------------
   task automatic start_op(input logic [3:0] m, input logic r, input logic [14:0] a, input logic [31:0] d);
      @(negedge clk);
      bif.mem_wmask = m;
      bif.mem_rstrb = r;
      bif.mem_addr  = a;
      bif.mem_wdata = d;
      @(posedge clk);
      #1;
      bif.mem_wmask = 4'b0000;
      bif.mem_rstrb = 1'b0;
      bif.mem_addr  = 15'($urandom);
      bif.mem_wdata = $urandom;
   endtask

   task automatic wait_op();
      lat = 0;
      cs_low = 0;
      saw_rb = 1'b0;
      saw_wb = 1'b0;
      while ((bif.mem_rbusy || bif.mem_wbusy) && lat < MAX_CYC) begin
         lat++;
         if (!bif.spi_cs_n) cs_low++;
         saw_rb = saw_rb | bif.mem_rbusy;
         saw_wb = saw_wb | bif.mem_wbusy;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_op(input string tag);
      logic [7:0] got;
      logic [7:0] want;
      int         i;
      check({tag, " latency"}, lat, exp_lat);
      check({tag, " cs_low"}, cs_low, CLK_DIV * (2 + 16 * exp_total));
      check({tag, " sck_rises"}, rise_cnt, 8 * exp_total);
      check({tag, " frame_bytes"}, rx_bytes.size(), exp_total);
      i = 0;
      while (exp_q.size() > 0) begin
         want = exp_q.pop_front();
         got = (i < rx_bytes.size()) ? rx_bytes[i] : 8'h00;
         check($sformatf("%s mosi_byte%0d", tag, i), got, want);
         i++;
      end
      check({tag, " busy_kind"}, {saw_wb, saw_rb}, exp_write ? 2'b10 : 2'b01);
      check({tag, " rdata"}, bif.mem_rdata, exp_rdata);
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic [3:0]  wmask;
      logic        rstrb;
      logic [14:0] addr;
      logic [31:0] wdata;
      logic [55:0] exp_frame;
      int          exp_cmp;
      int          exp_total;
      int          exp_lat;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t        tbl [9];
   vec_t        v;
   logic [55:0] fr;
   logic [3:0]  legal [7];
   logic [3:0]  r_m;
   logic        r_r;
   logic [14:0] r_a;
   logic [31:0] r_d;
   int          f0, r0, bad;

   initial begin
      checks = 0;
      errors = 0;
      for (int i = 0; i < 32768; i++) ref_mem[i] = 8'h00;
      legal = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};

      tbl[0] = '{4'b1111, 1'b0, 15'h0104, 32'hDEADBEEF, 56'h020104EFBEADDE, 7, 7, 230, 32'h00000000};
      tbl[1] = '{4'b0000, 1'b1, 15'h0106, 32'h00000000, 56'h03010400000000, 3, 7, 230, 32'hDEADBEEF};
      tbl[2] = '{4'b0100, 1'b0, 15'h0200, 32'h00AB0000, 56'h020202AB000000, 4, 4, 134, 32'hDEADBEEF};
      tbl[3] = '{4'b0000, 1'b1, 15'h0200, 32'h00000000, 56'h03020000000000, 3, 7, 230, 32'h00AB0000};
      tbl[4] = '{4'b0011, 1'b0, 15'h0300, 32'h12345678, 56'h02030078560000, 5, 5, 166, 32'h00AB0000};
      tbl[5] = '{4'b1000, 1'b0, 15'h0301, 32'h99000000, 56'h02030399000000, 4, 4, 134, 32'h00AB0000};
      tbl[6] = '{4'b0000, 1'b1, 15'h0302, 32'h00000000, 56'h03030000000000, 3, 7, 230, 32'h99005678};
      tbl[7] = '{4'b0101, 1'b0, 15'h0400, 32'h44332211, 56'h02040011223300, 6, 6, 198, 32'h99005678};
      tbl[8] = '{4'b0000, 1'b1, 15'h0403, 32'h00000000, 56'h03040000000000, 3, 7, 230, 32'h00332211};

      // reset and idle
      bif.mem_addr  = '0;
      bif.mem_wdata = 32'h0;
      bif.mem_wmask = 4'b0000;
      bif.mem_rstrb = 1'b0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset cs_n", bif.spi_cs_n, 1'b1);
      check("reset sck", bif.spi_sck, 1'b0);
      check("reset mosi", bif.spi_mosi, 1'b0);
      check("reset busy", {bif.mem_rbusy, bif.mem_wbusy}, 2'b00);
      check("reset rdata", bif.mem_rdata, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      r0 = total_rises;
      bad = 0;
      repeat (50) begin
         @(posedge clk);
         #1;
         if (bif.spi_cs_n !== 1'b1 || bif.mem_rbusy || bif.mem_wbusy) bad++;
      end
      check("idle sck_edges", total_rises - r0, 0);
      check("idle cs_busy", bad, 0);

      // directed table
      for (int i = 0; i < 9; i++) begin
         v = tbl[i];
         fr = v.exp_frame;
         exp_q.delete();
         for (int b = 0; b < v.exp_cmp; b++) exp_q.push_back(fr[55 - 8*b -: 8]);
         exp_total = v.exp_total;
         exp_lat   = v.exp_lat;
         exp_write = (v.wmask != 4'b0000);
         exp_rdata = v.exp_rdata;
         if (exp_write) ref_write(v.wmask, v.addr, v.wdata);
         start_op(v.wmask, v.rstrb, v.addr, v.wdata);
         wait_op();
         check_op($sformatf("vec%0d", i));
      end

      // requests while busy are ignored
      f0 = frame_cnt;
      start_op(4'b0000, 1'b1, 15'h0104, 32'h0);
      lat = 0;
      while ((bif.mem_rbusy || bif.mem_wbusy) && lat < MAX_CYC) begin
         lat++;
         bif.mem_rstrb = (lat == 50);
         bif.mem_addr  = (lat == 50) ? 15'h0700 : 15'h0000;
         bif.mem_wmask = (lat == 120) ? 4'b1111 : 4'b0000;
         @(posedge clk);
         #1;
      end
      bif.mem_rstrb = 1'b0;
      bif.mem_wmask = 4'b0000;
      check("busy_ignore latency", lat, 230);
      check("busy_ignore rdata", bif.mem_rdata, 32'hDEADBEEF);
      check("busy_ignore frames", frame_cnt - f0, 1);
      check("busy_ignore header", {rx_bytes[0], rx_bytes[1], rx_bytes[2]}, 24'h030104);
      bad = 0;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (bif.mem_rbusy || bif.mem_wbusy) bad++;
      end
      check("busy_ignore no_restart", bad, 0);
      check("busy_ignore frames_after", frame_cnt - f0, 1);

      // read and write on the same edge: write only
      exp_q = '{8'h02, 8'h05, 8'h00, 8'hFE, 8'hCA};
      exp_total = 5;
      exp_lat   = 166;
      exp_write = 1'b1;
      exp_rdata = 32'hDEADBEEF;
      ref_write(4'b0011, 15'h0500, 32'h0000CAFE);
      start_op(4'b0011, 1'b1, 15'h0500, 32'h0000CAFE);
      wait_op();
      check_op("rw_same_edge");

      // reset during SHIFT of a read
      r0 = total_rises;
      start_op(4'b0000, 1'b1, 15'h0300, 32'h0);
      repeat (40) @(posedge clk);
      #1;
      check("midreset in_shift", (total_rises - r0) > 0, 1'b1);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("midreset cs_n", bif.spi_cs_n, 1'b1);
      check("midreset sck", bif.spi_sck, 1'b0);
      check("midreset rbusy", bif.mem_rbusy, 1'b0);
      check("midreset rdata", bif.mem_rdata, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      exp_q = '{8'h03, 8'h03, 8'h00};
      exp_total = 7;
      exp_lat   = 230;
      exp_write = 1'b0;
      exp_rdata = 32'h99005678;
      start_op(4'b0000, 1'b1, 15'h0300, 32'h0);
      wait_op();
      check_op("after_reset_read");

      // random traffic in a small window so reads hit written data
      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(0, 1) == 1) begin
            r_m = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : legal[$urandom_range(0, 6)];
            r_r = 1'($urandom_range(0, 1));
         end else begin
            r_m = 4'b0000;
            r_r = 1'b1;
         end
         r_a = 15'h7000 + 15'($urandom_range(0, 63));
         r_d = $urandom;
         model_expect(r_m, r_a, r_d);
         start_op(r_m, r_r, r_a, r_d);
         wait_op();
         check_op($sformatf("rand%0d", it));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
